// File: rtl/mac_pkg.sv
// Shared definitions for the dot-product MAC: FSM encoding, lane-sum width
// and the accumulator clamp bounds.
package mac_pkg;

    typedef enum logic {
        S_ACC = 1'b0,
        S_OUT = 1'b1
    } state_e;

    // Widest accumulator the clamp-bound functions can describe.
    localparam int MAX_ACC_W = 128;

    // Width that holds the sum of LANES full-width products without loss.
    function automatic int sum_width(input int data_w, input int lanes);
        return 2 * data_w + $clog2(lanes);
    endfunction

    function automatic logic [MAX_ACC_W-1:0] clamp_max(input int acc_w, input int is_signed);
        logic [MAX_ACC_W-1:0] ones;
        ones = '1;
        if (is_signed != 0) begin
            return ones >> (MAX_ACC_W - acc_w + 1);
        end
        return ones >> (MAX_ACC_W - acc_w);
    endfunction

    function automatic logic [MAX_ACC_W-1:0] clamp_min(input int acc_w, input int is_signed);
        logic [MAX_ACC_W-1:0] v;
        v = '0;
        if (is_signed != 0) begin
            v[acc_w-1] = 1'b1;
        end
        return v;
    endfunction

endpackage

// File: rtl/mac_lane_sum.sv
// Combinational product/adder tree: sums LANES products of in_a[i]*in_b[i]
// at full width, treating operands as two's complement when SIGNED != 0.
module mac_lane_sum
    import mac_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int LANES  = 4,
    parameter int SIGNED = 0,
    localparam int SUM_W = sum_width(DATA_W, LANES)
) (
    input  logic [LANES*DATA_W-1:0] in_a,
    input  logic [LANES*DATA_W-1:0] in_b,
    output logic [SUM_W-1:0]        beat_sum
);

    logic [SUM_W-1:0] a_ext;
    logic [SUM_W-1:0] b_ext;
    logic [SUM_W-1:0] sum_v;

    function automatic logic [SUM_W-1:0] extend(input logic [DATA_W-1:0] v);
        return {{(SUM_W-DATA_W){(SIGNED != 0) && v[DATA_W-1]}}, v};
    endfunction

    // Operands are widened before multiplying so the truncated product is exact.
    always_comb begin
        a_ext = '0;
        b_ext = '0;
        sum_v = '0;
        for (int i = 0; i < LANES; i++) begin
            a_ext = extend(in_a[i*DATA_W +: DATA_W]);
            b_ext = extend(in_b[i*DATA_W +: DATA_W]);
            sum_v = sum_v + a_ext * b_ext;
        end
        beat_sum = sum_v;
    end

endmodule

// File: rtl/dot_product_mac.sv
// Streaming dot-product MAC: accumulates lane sums per beat with saturation
// and presents the vector result through a valid/ready output handshake.
module dot_product_mac
    import mac_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int LANES  = 4,
    parameter int ACC_W  = 24,
    parameter int SIGNED = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [LANES*DATA_W-1:0] in_a,
    input  logic [LANES*DATA_W-1:0] in_b,
    input  logic                    in_last,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [ACC_W-1:0]        out_data,
    output logic                    out_sat
);

    localparam int SUM_W = sum_width(DATA_W, LANES);
    localparam logic [MAX_ACC_W-1:0] MAX_WIDE = clamp_max(ACC_W, SIGNED);
    localparam logic [MAX_ACC_W-1:0] MIN_WIDE = clamp_min(ACC_W, SIGNED);
    localparam logic [ACC_W-1:0] ACC_MAX = MAX_WIDE[ACC_W-1:0];
    localparam logic [ACC_W-1:0] ACC_MIN = MIN_WIDE[ACC_W-1:0];

    state_e           state_q;
    state_e           state_d;
    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] acc_d;
    logic             sat_q;
    logic             sat_d;
    logic [ACC_W-1:0] out_data_q;
    logic [ACC_W-1:0] out_data_d;
    logic             out_sat_q;
    logic             out_sat_d;

    logic [SUM_W-1:0] beat_sum;
    logic [ACC_W:0]   acc_ext;
    logic [ACC_W:0]   sum_ext;
    logic [ACC_W:0]   total;
    logic [ACC_W-1:0] clamped;
    logic             clamp_hit;

    mac_lane_sum #(
        .DATA_W (DATA_W),
        .LANES  (LANES),
        .SIGNED (SIGNED)
    ) u_lane_sum (
        .in_a     (in_a),
        .in_b     (in_b),
        .beat_sum (beat_sum)
    );

    // One guard bit above ACC_W is enough: both addends already fit in ACC_W.
    always_comb begin
        acc_ext   = {(SIGNED != 0) && acc_q[ACC_W-1], acc_q};
        sum_ext   = {{(ACC_W+1-SUM_W){(SIGNED != 0) && beat_sum[SUM_W-1]}}, beat_sum};
        total     = acc_ext + sum_ext;
        clamped   = total[ACC_W-1:0];
        clamp_hit = 1'b0;
        if (SIGNED != 0) begin
            if (total[ACC_W] != total[ACC_W-1]) begin
                clamp_hit = 1'b1;
                clamped   = total[ACC_W] ? ACC_MIN : ACC_MAX;
            end
        end else if (total[ACC_W]) begin
            clamp_hit = 1'b1;
            clamped   = ACC_MAX;
        end
    end

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        sat_d      = sat_q;
        out_data_d = out_data_q;
        out_sat_d  = out_sat_q;
        case (state_q)
            S_ACC: begin
                if (in_valid) begin
                    acc_d = clamped;
                    sat_d = sat_q | clamp_hit;
                    if (in_last) begin
                        out_data_d = clamped;
                        out_sat_d  = sat_q | clamp_hit;
                        state_d    = S_OUT;
                    end
                end
            end
            S_OUT: begin
                if (out_ready) begin
                    state_d = S_ACC;
                    acc_d   = '0;
                    sat_d   = 1'b0;
                end
            end
            default: state_d = S_ACC;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= S_ACC;
            acc_q      <= '0;
            sat_q      <= 1'b0;
            out_data_q <= '0;
            out_sat_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            sat_q      <= sat_d;
            out_data_q <= out_data_d;
            out_sat_q  <= out_sat_d;
        end
    end

    assign in_ready  = (state_q == S_ACC);
    assign out_valid = (state_q == S_OUT);
    assign out_data  = out_data_q;
    assign out_sat   = out_sat_q;

endmodule
